mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
Memory-side responder for the ICACHE and DCACHE bus interfaces. It serves 256-bit line-fill requests from both caches and drains the DCACHE write buffer, serialising all traffic onto one 32-bit word-wide main-memory port. It owns read/write ordering: a DCACHE fill is never issued while write-buffer entries are pending.

Parameters:
LINE_WORDS, 8, words per cache line; fixed at 8 so that 8 x 32 = 256
WB_W, 68, write-buffer entry width, packed as {addr[67:36], data[35:4], be[3:0]}

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
icache_req_in  in  1  ICACHE fill request; held until icache_ready_out
icache_addr_in  in  32  ICACHE miss address; only bits [31:5] used
icache_ready_out  out  1  one-cycle pulse; icache_data_out valid this cycle
icache_data_out  out  256  filled line; word i at [32i+31:32i]
dcache_req_in  in  1  DCACHE fill request; held until dcache_ready_out
dcache_addr_in  in  32  DCACHE miss address; only bits [31:5] used
dcache_ready_out  out  1  one-cycle pulse; dcache_data_out valid this cycle
dcache_data_out  out  256  filled line, same word order as ICACHE
wb_empty_in  in  1  write buffer empty
wb_data_in  in  68  write-buffer head entry
wb_pop_en_out  out  1  one-cycle pop of the head entry
mem_req_out  out  1  memory beat request
mem_we_out  out  1  1 = write beat, 0 = read beat
mem_addr_out  out  32  word address; bits [1:0] = 0
mem_wdata_out  out  32  write data
mem_be_out  out  4  byte enables (4'hF on reads)
mem_ack_in  in  1  beat done; read data valid this cycle
mem_rdata_in  in  32  read data

Behaviour:
- Reset (asynchronous, active-low): state goes to IDLE. All outputs are 0, including both data buses. The beat counter and line buffer are cleared. A partial fill in progress is discarded with no ready pulse. A write beat in progress is abandoned with no pop, so the entry stays in the write buffer.
- States: IDLE, FILL, WB_WRITE, DONE.
- IDLE grant priority, evaluated each cycle:
  1. dcache_req_in && !wb_empty_in -> WB_WRITE (drain before DCACHE fill).
  2. dcache_req_in && wb_empty_in -> FILL, owner = D.
  3. icache_req_in -> FILL, owner = I.
  4. !wb_empty_in -> WB_WRITE (background drain).
  5. Otherwise stay in IDLE.
- Owner and line address ({addr[31:5], 5'b0}) are latched on grant.
- FILL:
  - mem_req_out=1, mem_we_out=0, mem_be_out=4'hF, mem_addr_out = {line[31:5], beat[2:0], 2'b00}.
  - Address is stable until ack.
  - On mem_ack_in, mem_rdata_in is written to word[beat] and beat increments.
  - On the ack for beat 7, go to DONE; the beat counter wraps to 0.
- WB_WRITE:
  - mem_req_out=1, mem_we_out=1; addr, data and be are taken from wb_data_in fields.
  - wb_pop_en_out = mem_ack_in (combinational, same cycle as ack). Then go to DONE.
- DONE, always one cycle:
  - If the last transaction was a fill, the owner's ready_out = 1 and its data_out carries the line buffer.
  - No ready pulse follows a write.
  - Then return to IDLE. This guarantees that a request still asserted during the ready cycle is not re-granted.
- mem_req_out is 0 in IDLE and DONE. mem_ack_in is ignored outside FILL and WB_WRITE.
- Latency with zero-wait memory (ack in the same cycle as req):
  - Grant in IDLE at cycle 0, beats at cycles 1..8, ready at cycle 9.
  - Write drain: 3 cycles per entry.
- With k pending write-buffer entries, a DCACHE fill waits for k drains before it is granted.
- ICACHE fills are not ordered against the write buffer; self-modifying code is unsupported.
- A request dropped mid-fill is illegal. The fill completes and the ready pulse is still issued.
- A data_out bus holds its last line until the next fill for the same owner completes.

Decomposition:
- Package mem_bus_pkg holds:
  - State enum: IDLE, FILL, WB_WRITE, DONE.
  - LINE_WORDS and the beat-index width.
  - WB field offsets: WB_ADDR_HI=67, WB_ADDR_LO=36, WB_DATA_HI=35, WB_DATA_LO=4, WB_BE_HI=3.
  - Owner encoding: OWN_I, OWN_D.
- Sub-module line_fill_buffer holds the beat counter, per-word write enable, the 256-bit register and the last-beat flag.
- The FSM and address/mux logic stay in the top.

Test Plan:
- dcache_req_in=1, addr 0x0000_1234, wb empty, memory returns word i = 0xA0+i with zero wait -> mem_addr sequence 0x1220..0x123C; dcache_ready_out pulses at cycle 9; dcache_data_out[31:0]=0xA0, [255:224]=0xA7.
- Write buffer holds 2 entries {0x100, 0xDEADBEEF, 4'h3} and {0x104, 0x11223344, 4'hF}, plus dcache_req_in -> two write beats with matching addr/data/be, two wb_pop_en_out pulses, then the fill starts; no read beat precedes either write.
- icache_req_in and dcache_req_in are raised in the same cycle with wb empty -> DCACHE is served first, ICACHE immediately after DONE; each ready pulse goes only to its owner.
- Memory acks with 3 wait states per beat -> mem_addr_out is held stable across the wait states; ready arrives at cycle 33; mem_req_out stays high throughout.
- rst_n is asserted asynchronously after beat 4 of a fill -> all outputs go to 0 immediately; after release, a re-issued request refetches from beat 0 and returns a correct line.
- A requester holds req high through the cycle after ready -> exactly one fill is performed and exactly one ready pulse is issued.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared types and constants for the memory bus arbiter
package mem_bus_pkg;
   localparam int LINE_WORDS = 8;
   localparam int BEAT_W     = $clog2(LINE_WORDS);
   localparam int LINE_BITS  = LINE_WORDS * 32;

   // Write-buffer entry layout: {addr, data, be}
   localparam int WB_W       = 68;
   localparam int WB_ADDR_HI = 67;
   localparam int WB_ADDR_LO = 36;
   localparam int WB_DATA_HI = 35;
   localparam int WB_DATA_LO = 4;
   localparam int WB_BE_HI   = 3;

   typedef enum logic [1:0] {IDLE, FILL, WB_WRITE, DONE} state_t;
   typedef enum logic {OWN_I, OWN_D} owner_t;
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - cache, write-buffer and main-memory signals of the arbiter
interface mem_bus_arbiter_if;
   import mem_bus_pkg::*;

   logic                 icache_req_in;
   logic [31:0]          icache_addr_in;
   logic                 icache_ready_out;
   logic [LINE_BITS-1:0] icache_data_out;
   logic                 dcache_req_in;
   logic [31:0]          dcache_addr_in;
   logic                 dcache_ready_out;
   logic [LINE_BITS-1:0] dcache_data_out;
   logic                 wb_empty_in;
   logic [WB_W-1:0]      wb_data_in;
   logic                 wb_pop_en_out;
   logic                 mem_req_out;
   logic                 mem_we_out;
   logic [31:0]          mem_addr_out;
   logic [31:0]          mem_wdata_out;
   logic [3:0]           mem_be_out;
   logic                 mem_ack_in;
   logic [31:0]          mem_rdata_in;

   modport slave (
      input  icache_req_in, icache_addr_in, dcache_req_in, dcache_addr_in,
      input  wb_empty_in, wb_data_in, mem_ack_in, mem_rdata_in,
      output icache_ready_out, icache_data_out, dcache_ready_out, dcache_data_out,
      output wb_pop_en_out, mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out, mem_be_out
   );

   modport master (
      output icache_req_in, icache_addr_in, dcache_req_in, dcache_addr_in,
      output wb_empty_in, wb_data_in, mem_ack_in, mem_rdata_in,
      input  icache_ready_out, icache_data_out, dcache_ready_out, dcache_data_out,
      input  wb_pop_en_out, mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out, mem_be_out
   );
endinterface

// File: rtl/line_fill_buffer.sv
// rtl/line_fill_buffer.sv - collects read beats into one cache line
module line_fill_buffer
   import mem_bus_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 we,
   input  logic [31:0]          wdata,
   output logic [BEAT_W-1:0]    beat,
   output logic [LINE_BITS-1:0] line,
   output logic                 last_beat
);
   logic [LINE_WORDS-1:0] word_we;

   always_comb begin
      word_we = '0;
      word_we[beat] = we;
   end

   // Beat counter wraps to 0 after the last word, ready for the next fill
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat <= '0;
         line <= '0;
      end else begin
         for (int i = 0; i < LINE_WORDS; i++) begin
            if (word_we[i]) line[i*32 +: 32] <= wdata;
         end
         if (we) beat <= beat + BEAT_W'(1);
      end
   end

   assign last_beat = (beat == BEAT_W'(LINE_WORDS - 1));
endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - serialises ICACHE/DCACHE line fills and write-buffer drains
// onto one word-wide memory port; DCACHE fills never overtake pending writes.
module mem_bus_arbiter
   import mem_bus_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   mem_bus_arbiter_if.slave bus
);
   state_t               state;
   owner_t               owner;
   logic                 is_fill;
   logic [26:0]          line_addr;
   logic [LINE_BITS-1:0] i_line_q;
   logic [LINE_BITS-1:0] d_line_q;

   logic                 fill_we;
   logic [BEAT_W-1:0]    beat;
   logic [LINE_BITS-1:0] line;
   logic                 last_beat;
   logic                 done_fill;
   logic                 unused_bits;

   assign fill_we = (state == FILL) && bus.mem_ack_in;

   line_fill_buffer u_line_fill_buffer (
      .clk       (clk),
      .rst_n     (rst_n),
      .we        (fill_we),
      .wdata     (bus.mem_rdata_in),
      .beat      (beat),
      .line      (line),
      .last_beat (last_beat)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         owner     <= OWN_I;
         is_fill   <= 1'b0;
         line_addr <= '0;
         i_line_q  <= '0;
         d_line_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               // A DCACHE request first drains the write buffer to keep read-after-write order
               if (bus.dcache_req_in && !bus.wb_empty_in) begin
                  state   <= WB_WRITE;
                  is_fill <= 1'b0;
               end else if (bus.dcache_req_in) begin
                  state     <= FILL;
                  owner     <= OWN_D;
                  is_fill   <= 1'b1;
                  line_addr <= bus.dcache_addr_in[31:5];
               end else if (bus.icache_req_in) begin
                  state     <= FILL;
                  owner     <= OWN_I;
                  is_fill   <= 1'b1;
                  line_addr <= bus.icache_addr_in[31:5];
               end else if (!bus.wb_empty_in) begin
                  state   <= WB_WRITE;
                  is_fill <= 1'b0;
               end
            end
            FILL:     if (bus.mem_ack_in && last_beat) state <= DONE;
            WB_WRITE: if (bus.mem_ack_in) state <= DONE;
            DONE: begin
               state <= IDLE;
               if (is_fill && owner == OWN_I) i_line_q <= line;
               if (is_fill && owner == OWN_D) d_line_q <= line;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign done_fill            = (state == DONE) && is_fill;
   assign bus.icache_ready_out = done_fill && (owner == OWN_I);
   assign bus.dcache_ready_out = done_fill && (owner == OWN_D);
   assign bus.icache_data_out  = bus.icache_ready_out ? line : i_line_q;
   assign bus.dcache_data_out  = bus.dcache_ready_out ? line : d_line_q;
   assign bus.wb_pop_en_out    = (state == WB_WRITE) && bus.mem_ack_in;

   always_comb begin
      bus.mem_req_out   = 1'b0;
      bus.mem_we_out    = 1'b0;
      bus.mem_addr_out  = '0;
      bus.mem_wdata_out = '0;
      bus.mem_be_out    = '0;
      if (state == FILL) begin
         bus.mem_req_out  = 1'b1;
         bus.mem_addr_out = {line_addr, beat, 2'b00};
         bus.mem_be_out   = 4'hF;
      end else if (state == WB_WRITE) begin
         bus.mem_req_out   = 1'b1;
         bus.mem_we_out    = 1'b1;
         bus.mem_addr_out  = {bus.wb_data_in[WB_ADDR_HI:WB_ADDR_LO+2], 2'b00};
         bus.mem_wdata_out = bus.wb_data_in[WB_DATA_HI:WB_DATA_LO];
         bus.mem_be_out    = bus.wb_data_in[WB_BE_HI:0];
      end
   end

   assign unused_bits = ^{bus.icache_addr_in[4:0], bus.dcache_addr_in[4:0],
                          bus.wb_data_in[WB_ADDR_LO+1:WB_ADDR_LO]};
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
   import mem_bus_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mem_bus_arbiter_if bus ();

   mem_bus_arbiter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Memory and write-buffer model state
   int              wait_states = 0;
   int              wait_cnt    = 0;
   logic [31:0]     rd_base     = 32'hA0;
   logic [WB_W-1:0] wb_q[$];
   bit              pop_pending = 0;

   // Observation logs
   logic [31:0] beat_addr[$];
   logic        beat_we[$];
   logic [31:0] beat_wdata[$];
   logic [3:0]  beat_be[$];
   logic [31:0] req_addr[$];
   int          pop_cnt = 0;
   int          i_rdy_cnt = 0;
   int          d_rdy_cnt = 0;

   always @(negedge clk) begin
      if (pop_pending) begin
         void'(wb_q.pop_front());
         pop_pending = 0;
      end
      bus.wb_empty_in = (wb_q.size() == 0);
      bus.wb_data_in  = (wb_q.size() != 0) ? wb_q[0] : '0;
      if (bus.mem_ack_in) wait_cnt = 0;
      if (bus.mem_req_out) begin
         if (wait_cnt >= wait_states) begin
            bus.mem_ack_in = 1'b1;
         end else begin
            bus.mem_ack_in = 1'b0;
            wait_cnt++;
         end
      end else begin
         bus.mem_ack_in = 1'b0;
         wait_cnt = 0;
      end
      bus.mem_rdata_in = rd_base + 32'(bus.mem_addr_out[4:2])
                         + (bus.mem_addr_out[16] ? 32'h100 : 32'h0);
   end

   always @(posedge clk) begin
      if (bus.mem_req_out) req_addr.push_back(bus.mem_addr_out);
      if (bus.mem_req_out && bus.mem_ack_in) begin
         beat_addr.push_back(bus.mem_addr_out);
         beat_we.push_back(bus.mem_we_out);
         beat_wdata.push_back(bus.mem_wdata_out);
         beat_be.push_back(bus.mem_be_out);
      end
      if (bus.wb_pop_en_out) begin
         pop_cnt++;
         pop_pending = 1;
      end
      if (bus.icache_ready_out) i_rdy_cnt++;
      if (bus.dcache_ready_out) d_rdy_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_logs();
      beat_addr.delete();
      beat_we.delete();
      beat_wdata.delete();
      beat_be.delete();
      req_addr.delete();
   endtask

   task automatic wait_ready(input bit want_d, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!(want_d ? bus.dcache_ready_out : bus.icache_ready_out) && n < 200);
   endtask

   function automatic logic [255:0] exp_line(input logic [31:0] base);
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
      return l;
   endfunction

   initial begin
      int n;
      int d_before;
      int p_before;
      int guard;

      rst_n = 1'b0;
      bus.icache_req_in  = 1'b0;
      bus.icache_addr_in = '0;
      bus.dcache_req_in  = 1'b0;
      bus.dcache_addr_in = '0;
      bus.wb_empty_in    = 1'b1;
      bus.wb_data_in     = '0;
      bus.mem_ack_in     = 1'b0;
      bus.mem_rdata_in   = '0;
      repeat (2) tick();
      chk("rst_mem_req", 256'(bus.mem_req_out), 256'(0));
      chk("rst_d_ready", 256'(bus.dcache_ready_out), 256'(0));
      chk("rst_i_data", bus.icache_data_out, '0);
      chk("rst_d_data", bus.dcache_data_out, '0);
      chk("rst_pop", 256'(bus.wb_pop_en_out), 256'(0));
      rst_n = 1'b1;
      tick();

      // Zero-wait DCACHE fill
      clear_logs();
      bus.dcache_addr_in = 32'h0000_1234;
      bus.dcache_req_in  = 1'b1;
      wait_ready(1, n);
      chk("d_fill_latency", 256'(n), 256'(9));
      chk("d_word0", 256'(bus.dcache_data_out[31:0]), 256'(32'hA0));
      chk("d_word7", 256'(bus.dcache_data_out[255:224]), 256'(32'hA7));
      chk("d_line", bus.dcache_data_out, exp_line(32'hA0));
      chk("d_fill_no_i_ready", 256'(bus.icache_ready_out), 256'(0));
      bus.dcache_req_in = 1'b0;
      tick();
      chk("d_ready_one_cycle", 256'(bus.dcache_ready_out), 256'(0));
      chk("d_data_held", bus.dcache_data_out, exp_line(32'hA0));
      chk("d_beats", 256'(beat_addr.size()), 256'(8));
      for (int i = 0; i < 8; i++)
         chk($sformatf("d_addr%0d", i), 256'(beat_addr[i]), 256'(32'h1220 + 32'(4*i)));

      // Two pending writes must drain before the DCACHE fill
      clear_logs();
      p_before = pop_cnt;
      wb_q.push_back({32'h100, 32'hDEADBEEF, 4'h3});
      wb_q.push_back({32'h104, 32'h11223344, 4'hF});
      bus.dcache_addr_in = 32'h0000_2000;
      bus.dcache_req_in  = 1'b1;
      wait_ready(1, n);
      chk("wb_then_fill_latency", 256'(n), 256'(15));
      chk("wb_fill_line", bus.dcache_data_out, exp_line(32'hA0));
      bus.dcache_req_in = 1'b0;
      tick();
      chk("wb_pops", 256'(pop_cnt - p_before), 256'(2));
      chk("wb_beats", 256'(beat_addr.size()), 256'(10));
      chk("wb0_we", 256'(beat_we[0]), 256'(1));
      chk("wb0_addr", 256'(beat_addr[0]), 256'(32'h100));
      chk("wb0_data", 256'(beat_wdata[0]), 256'(32'hDEADBEEF));
      chk("wb0_be", 256'(beat_be[0]), 256'(4'h3));
      chk("wb1_we", 256'(beat_we[1]), 256'(1));
      chk("wb1_addr", 256'(beat_addr[1]), 256'(32'h104));
      chk("wb1_data", 256'(beat_wdata[1]), 256'(32'h11223344));
      chk("wb1_be", 256'(beat_be[1]), 256'(4'hF));
      chk("wb_fill_first_read", 256'({beat_we[2], beat_addr[2]}), 256'({1'b0, 32'h2000}));
      chk("wb_fill_be", 256'(beat_be[2]), 256'(4'hF));

      // Simultaneous requests: DCACHE first, ICACHE right after
      clear_logs();
      d_before = d_rdy_cnt;
      bus.dcache_addr_in = 32'h0000_3000;
      bus.icache_addr_in = 32'h0001_0040;
      bus.dcache_req_in  = 1'b1;
      bus.icache_req_in  = 1'b1;
      wait_ready(1, n);
      chk("both_d_latency", 256'(n), 256'(9));
      chk("both_no_i_ready", 256'(bus.icache_ready_out), 256'(0));
      bus.dcache_req_in = 1'b0;
      wait_ready(0, n);
      chk("both_i_latency", 256'(n), 256'(10));
      chk("both_no_d_ready", 256'(bus.dcache_ready_out), 256'(0));
      chk("both_i_line", bus.icache_data_out, exp_line(32'h1A0));
      chk("both_d_held", bus.dcache_data_out, exp_line(32'hA0));
      chk("both_i_addr0", 256'(beat_addr[8]), 256'(32'h10040));
      bus.icache_req_in = 1'b0;
      tick();
      chk("both_d_pulses", 256'(d_rdy_cnt - d_before), 256'(1));

      // Three wait states per beat
      clear_logs();
      wait_states = 3;
      bus.icache_addr_in = 32'h0000_4000;
      bus.icache_req_in  = 1'b1;
      wait_ready(0, n);
      chk("ws_latency", 256'(n), 256'(33));
      chk("ws_line", bus.icache_data_out, exp_line(32'hA0));
      bus.icache_req_in = 1'b0;
      chk("ws_req_cycles", 256'(req_addr.size()), 256'(32));
      for (int k = 0; k < 32; k++)
         chk($sformatf("ws_addr%0d", k), 256'(req_addr[k]), 256'(32'h4000 + 32'(4*(k/4))));
      tick();
      wait_states = 0;
      tick();

      // Asynchronous reset in the middle of a fill
      clear_logs();
      d_before = d_rdy_cnt;
      bus.dcache_addr_in = 32'h0000_5000;
      bus.dcache_req_in  = 1'b1;
      guard = 0;
      while (beat_addr.size() < 5 && guard < 50) begin
         tick();
         guard++;
      end
      chk("rst_mid_reached_beat4", 256'(beat_addr.size() >= 5), 256'(1));
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_mem_req", 256'(bus.mem_req_out), 256'(0));
      chk("arst_mem_addr", 256'(bus.mem_addr_out), 256'(0));
      chk("arst_mem_be", 256'(bus.mem_be_out), 256'(0));
      chk("arst_d_data", bus.dcache_data_out, '0);
      chk("arst_i_data", bus.icache_data_out, '0);
      chk("arst_d_ready", 256'(bus.dcache_ready_out), 256'(0));
      bus.dcache_req_in = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      chk("arst_no_pulse", 256'(d_rdy_cnt - d_before), 256'(0));
      clear_logs();
      bus.dcache_req_in = 1'b1;
      wait_ready(1, n);
      chk("refetch_latency", 256'(n), 256'(9));
      chk("refetch_line", bus.dcache_data_out, exp_line(32'hA0));
      chk("refetch_beat0", 256'(beat_addr[0]), 256'(32'h5000));
      bus.dcache_req_in = 1'b0;
      tick();

      // Request held through the ready cycle is not re-granted
      clear_logs();
      d_before = i_rdy_cnt;
      bus.icache_addr_in = 32'h0000_6000;
      bus.icache_req_in  = 1'b1;
      wait_ready(0, n);
      chk("hold_latency", 256'(n), 256'(9));
      tick();
      chk("hold_idle_no_req", 256'(bus.mem_req_out), 256'(0));
      chk("hold_no_second_ready", 256'(bus.icache_ready_out), 256'(0));
      bus.icache_req_in = 1'b0;
      repeat (12) tick();
      chk("hold_one_pulse", 256'(i_rdy_cnt - d_before), 256'(1));
      chk("hold_one_fill", 256'(beat_addr.size()), 256'(8));

      // Background drain with no cache requests
      clear_logs();
      p_before = pop_cnt;
      d_before = i_rdy_cnt + d_rdy_cnt;
      wb_q.push_back({32'h200, 32'hCAFEF00D, 4'h5});
      repeat (5) tick();
      chk("bg_pop", 256'(pop_cnt - p_before), 256'(1));
      chk("bg_beats", 256'(beat_addr.size()), 256'(1));
      chk("bg_write", 256'({beat_we[0], beat_addr[0], beat_wdata[0], beat_be[0]}),
          256'({1'b1, 32'h200, 32'hCAFEF00D, 4'h5}));
      chk("bg_no_ready", 256'(i_rdy_cnt + d_rdy_cnt - d_before), 256'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
